uart_rx_cmd_decoder: RTL and testbench
======================================

Name: uart_rx_cmd_decoder

Overview:
Command-frame decoder that sits directly downstream of the UART receiver. It consumes the receiver's validated parallel bytes (one-cycle DATA_Valid strobes) and assembles them into register-file read/write and ALU commands. It drives the register file and ALU strobes, and pushes response bytes into the TX FIFO. Single clock domain: the same domain as the RX output after synchronisation.

Parameters:
DATA_WIDTH, 8, width of the byte and register-file data paths
ADDR_WIDTH, 4, register-file address width
TIMEOUT, 16'd4096, maximum number of idle cycles allowed between bytes of one frame

Ports:
CLK  input  1  system clock
RST_n  input  1  asynchronous active-low reset
RX_P_DATA  input  DATA_WIDTH  received byte; sampled only when RX_D_VLD=1
RX_D_VLD  input  1  one-cycle strobe marking a new byte
RF_RdData  input  DATA_WIDTH  register-file read data
RF_RdData_Valid  input  1  register-file read data valid
ALU_OUT  input  2*DATA_WIDTH  ALU result
ALU_OUT_VLD  input  1  ALU result valid
TX_FIFO_FULL  input  1  TX FIFO cannot accept a write
RF_WrEn  output  1  register-file write strobe, one cycle
RF_RdEn  output  1  register-file read strobe, one cycle
RF_Address  output  ADDR_WIDTH  register-file address
RF_WrData  output  DATA_WIDTH  register-file write data
ALU_EN  output  1  ALU start strobe, one cycle
ALU_FUN  output  4  ALU function code
CLK_GATE_EN  output  1  ALU clock-gate enable
TX_P_DATA  output  DATA_WIDTH  response byte to TX FIFO
TX_D_VLD  output  1  TX FIFO write strobe, one cycle
FRAME_ERR  output  1  one-cycle pulse on a bad command or a timeout

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0.
- All outputs are registered. Strobes assert on the clock edge after the triggering byte or event.
- Command bytes, sampled in IDLE:
  - 0xAA: RF write; frame = cmd, addr, data.
  - 0xBB: RF read; frame = cmd, addr.
  - 0xCC: ALU op with operands; frame = cmd, A, B, fun.
  - 0xDD: ALU op without operands; frame = cmd, fun.
  - Any other byte: FRAME_ERR pulse, stay in IDLE.
- State machine (each arrow is taken on RX_D_VLD unless stated):
  - IDLE -> WR_ADDR | RD_ADDR | OP_A | ALU_FN.
  - WR_ADDR -> WR_DATA, latching RX_P_DATA[ADDR_WIDTH-1:0]. Upper address bits are ignored.
  - WR_DATA -> IDLE, issuing RF_WrEn=1 with RF_WrData.
  - RD_ADDR -> RD_WAIT, issuing RF_RdEn=1.
  - RD_WAIT -> TX_RD on RF_RdData_Valid, capturing the data.
  - OP_A: write A to address 0 (RF_WrEn pulse) -> OP_B.
  - OP_B: write B to address 1 -> ALU_FN.
  - ALU_FN -> ALU_WAIT, latching RX_P_DATA[3:0] to ALU_FUN and pulsing ALU_EN.
  - ALU_WAIT -> TX_LO on ALU_OUT_VLD, capturing the 16-bit result.
  - TX_RD: push the byte -> IDLE.
  - TX_LO: push ALU_OUT[7:0] -> TX_HI.
  - TX_HI: push ALU_OUT[15:8] -> IDLE.
- TX handshake:
  - A TX_D_VLD pulse is issued only in a cycle where TX_FIFO_FULL=0.
  - While the FIFO is full, the decoder holds in the TX state with the byte stable and does not drop it.
  - RX bytes arriving during any TX or WAIT state are discarded, with no error.
- CLK_GATE_EN: 1 in ALU_FN, ALU_WAIT, TX_LO and TX_HI; 0 elsewhere. It is registered, so it rises one cycle before ALU_EN.
- Timeout:
  - The counter runs in every non-IDLE state.
  - It clears on each accepted RX byte and on each state transition.
  - On reaching TIMEOUT-1: return to IDLE, pulse FRAME_ERR, issue no strobes.
- Back-to-back RX_D_VLD on consecutive cycles is legal; each byte is consumed in order.
- Asynchronous reset mid-frame discards the partial frame and all pending responses.

Decomposition:
- Shared package uart_sys_pkg:
  - command opcode constants (CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD);
  - state encoding localparams;
  - operand register addresses (ADDR_OP_A=0, ADDR_OP_B=1).
- One sub-module, cmd_timeout_cnt: a loadable counter with clear input, enable input and an expire flag.

Test Plan:
- RF write: bytes AA,05,3C -> exactly one RF_WrEn pulse with RF_Address=5 and RF_WrData=0x3C, one cycle after the 3C strobe. No TX_D_VLD.
- RF read: bytes BB,05, then RF_RdData=0x3C with valid -> RF_RdEn pulse with address 5. One TX_D_VLD pulse with TX_P_DATA=0x3C.
- ALU with operands: bytes CC,0A,03,00, then ALU_OUT=0x000D with valid:
  - RF writes (0,0x0A) then (1,0x03);
  - ALU_FUN=0 with an ALU_EN pulse, CLK_GATE_EN high;
  - TX bytes 0x0D then 0x00.
- TX backpressure: ALU_OUT=0x1234 with TX_FIFO_FULL held high for 10 cycles -> no TX_D_VLD while full. Afterwards bytes 0x34 then 0x12, with no loss.
- Errors:
  - byte 0x55 in IDLE -> FRAME_ERR pulse, no strobes;
  - AA,05 followed by TIMEOUT idle cycles -> FRAME_ERR, return to IDLE, no RF_WrEn.
- Reset mid-frame: AA,05, then RST_n asserted low for 2 cycles, then BB,05 -> no write. The read completes normally.

Source files
------------

// File: rtl/uart_sys_pkg.sv
// Shared definitions for the UART command path: opcodes, FSM encoding,
// operand register addresses and small state-classification helpers.
package uart_sys_pkg;

  // Command opcodes recognised in IDLE
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file locations that hold the ALU operands
  localparam int unsigned ADDR_OP_A = 32'd0;
  localparam int unsigned ADDR_OP_B = 32'd1;

  // Decoder state encoding
  localparam int STATE_W = 32'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_OP_A     = 4'd5,
    ST_OP_B     = 4'd6,
    ST_ALU_FN   = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_TX_RD    = 4'd9,
    ST_TX_LO    = 4'd10,
    ST_TX_HI    = 4'd11
  } state_e;

  // States during which the ALU clock must be running
  function automatic logic gates_alu_clk(input state_e st);
    logic r;
    case (st)
      ST_ALU_FN, ST_ALU_WAIT, ST_TX_LO, ST_TX_HI: r = 1'b1;
      default:                                   r = 1'b0;
    endcase
    return r;
  endfunction

  // States that consume an RX byte as part of the current frame
  function automatic logic takes_rx_byte(input state_e st);
    logic r;
    case (st)
      ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
      ST_OP_A, ST_OP_B, ST_ALU_FN:               r = 1'b1;
      default:                                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Inter-byte watchdog: counts while enabled, clears on request and flags
// when the count reaches LIMIT-1 so the decoder can abandon the frame.
module cmd_timeout_cnt #(
  parameter int              CNT_W = 16,
  parameter logic [CNT_W-1:0] LIMIT = 16'd4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise advance while enabled
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = en && (count_q == (LIMIT - CNT_W'(1)));

endmodule

// File: rtl/uart_rx_cmd_decoder.sv
// Frame decoder between the UART receiver and the register file / ALU.
// Assembles RF write/read and ALU command frames from RX bytes, issues
// one-cycle strobes, and returns read/ALU results as bytes to the TX FIFO.
module uart_rx_cmd_decoder
  import uart_sys_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          ADDR_WIDTH = 4,
  parameter logic [15:0] TIMEOUT    = 16'd4096
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    TX_FIFO_FULL,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    FRAME_ERR
);

  state_e                  state_q, state_d;
  logic                    rf_wr_en_q, rf_wr_en_d;
  logic                    rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_WIDTH-1:0]   rf_address_q, rf_address_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                    alu_en_q, alu_en_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic                    clk_gate_en_q, clk_gate_en_d;
  logic [DATA_WIDTH-1:0]   tx_p_data_q, tx_p_data_d;
  logic                    tx_d_vld_q, tx_d_vld_d;
  logic                    frame_err_q, frame_err_d;
  logic [DATA_WIDTH-1:0]   res_hi_q, res_hi_d;

  logic                    tmo_expire_s;
  logic                    tmo_clr_s;
  logic                    tmo_en_s;

  // The watchdog restarts on every consumed byte and every state change
  assign tmo_en_s  = (state_q != ST_IDLE);
  assign tmo_clr_s = (state_q == ST_IDLE) || (state_d != state_q) ||
                     (RX_D_VLD && takes_rx_byte(state_q));

  cmd_timeout_cnt #(
    .CNT_W (16),
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk    (CLK),
    .rst_n  (RST_n),
    .clr    (tmo_clr_s),
    .en     (tmo_en_s),
    .expire (tmo_expire_s)
  );

  // Next-state and next-output logic; strobes default low, held values hold
  always_comb begin
    state_d      = state_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    tx_d_vld_d   = 1'b0;
    frame_err_d  = 1'b0;
    rf_address_d = rf_address_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    tx_p_data_d  = tx_p_data_q;
    res_hi_d     = res_hi_q;

    if (tmo_expire_s) begin
      // Abandon the frame silently apart from the error pulse
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              CMD_RF_WR:   state_d = ST_WR_ADDR;
              CMD_RF_RD:   state_d = ST_RD_ADDR;
              CMD_ALU_OP:  state_d = ST_OP_A;
              CMD_ALU_NOP: state_d = ST_ALU_FN;
              default:     frame_err_d = 1'b1;
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WR_ADDR: begin
          if (RX_D_VLD) begin
            rf_address_d = RX_P_DATA[ADDR_WIDTH-1:0];
            state_d      = ST_WR_DATA;
          end else begin
            state_d = ST_WR_ADDR;
          end
        end
        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            rf_wr_data_d = RX_P_DATA;
            rf_wr_en_d   = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_WR_DATA;
          end
        end
        ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            rf_address_d = RX_P_DATA[ADDR_WIDTH-1:0];
            rf_rd_en_d   = 1'b1;
            state_d      = ST_RD_WAIT;
          end else begin
            state_d = ST_RD_ADDR;
          end
        end
        ST_RD_WAIT: begin
          if (RF_RdData_Valid) begin
            tx_p_data_d = RF_RdData;
            state_d     = ST_TX_RD;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
        ST_OP_A: begin
          if (RX_D_VLD) begin
            rf_address_d = ADDR_WIDTH'(ADDR_OP_A);
            rf_wr_data_d = RX_P_DATA;
            rf_wr_en_d   = 1'b1;
            state_d      = ST_OP_B;
          end else begin
            state_d = ST_OP_A;
          end
        end
        ST_OP_B: begin
          if (RX_D_VLD) begin
            rf_address_d = ADDR_WIDTH'(ADDR_OP_B);
            rf_wr_data_d = RX_P_DATA;
            rf_wr_en_d   = 1'b1;
            state_d      = ST_ALU_FN;
          end else begin
            state_d = ST_OP_B;
          end
        end
        ST_ALU_FN: begin
          if (RX_D_VLD) begin
            alu_fun_d = RX_P_DATA[3:0];
            alu_en_d  = 1'b1;
            state_d   = ST_ALU_WAIT;
          end else begin
            state_d = ST_ALU_FN;
          end
        end
        ST_ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            tx_p_data_d = ALU_OUT[DATA_WIDTH-1:0];
            res_hi_d    = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
            state_d     = ST_TX_LO;
          end else begin
            state_d = ST_ALU_WAIT;
          end
        end
        ST_TX_RD: begin
          if (!TX_FIFO_FULL) begin
            tx_d_vld_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_TX_RD;
          end
        end
        ST_TX_LO: begin
          if (!TX_FIFO_FULL) begin
            tx_d_vld_d = 1'b1;
            state_d    = ST_TX_HI;
          end else begin
            state_d = ST_TX_LO;
          end
        end
        ST_TX_HI: begin
          // Low byte has already been pushed; present the high byte now
          tx_p_data_d = res_hi_q;
          if (!TX_FIFO_FULL) begin
            tx_d_vld_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_TX_HI;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Registered from the next state so the gate opens ahead of ALU_EN
    clk_gate_en_d = gates_alu_clk(state_d);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q       <= ST_IDLE;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_address_q  <= '0;
      rf_wr_data_q  <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= 4'h0;
      clk_gate_en_q <= 1'b0;
      tx_p_data_q   <= '0;
      tx_d_vld_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      res_hi_q      <= '0;
    end else begin
      state_q       <= state_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_address_q  <= rf_address_d;
      rf_wr_data_q  <= rf_wr_data_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      clk_gate_en_q <= clk_gate_en_d;
      tx_p_data_q   <= tx_p_data_d;
      tx_d_vld_q    <= tx_d_vld_d;
      frame_err_q   <= frame_err_d;
      res_hi_q      <= res_hi_d;
    end
  end

  assign RF_WrEn     = rf_wr_en_q;
  assign RF_RdEn     = rf_rd_en_q;
  assign RF_Address  = rf_address_q;
  assign RF_WrData   = rf_wr_data_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = clk_gate_en_q;
  assign TX_P_DATA   = tx_p_data_q;
  assign TX_D_VLD    = tx_d_vld_q;
  assign FRAME_ERR   = frame_err_q;

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Bench for uart_rx_cmd_decoder: directed frame table, hand-written
// backpressure / timeout / reset sequences, and random frames checked
// against a frame-level model of the command protocol.
module tb_uart_rx_cmd_decoder;

  localparam logic [15:0] TO = 16'd4096;

  logic        CLK, RST_n;
  logic [7:0]  RX_P_DATA, RF_RdData, RF_WrData, TX_P_DATA;
  logic        RX_D_VLD, RF_RdData_Valid, ALU_OUT_VLD, TX_FIFO_FULL;
  logic [15:0] ALU_OUT;
  logic        RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD, FRAME_ERR;
  logic [3:0]  RF_Address, ALU_FUN;

  uart_rx_cmd_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_n(RST_n), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .TX_FIFO_FULL(TX_FIFO_FULL),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .FRAME_ERR(FRAME_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected effect of one frame: bytes (first in [31:24]) plus response data
  typedef struct {
    logic [31:0] bytes;
    int          nb;
    logic [15:0] resp;
    int          nwr;  logic [11:0] wr0, wr1;   // {addr, data}
    int          nrd;  logic [3:0]  ra;
    int          nalu; logic [3:0]  fun;
    int          ntx;  logic [15:0] txb;        // first byte in [7:0]
    int          nerr;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  int cur_id = 0;

  // Event log collected from the DUT outputs
  logic [11:0] m_wr[$];
  logic [3:0]  m_rd[$];
  logic [3:0]  m_alu[$];
  logic [7:0]  m_tx[$];
  int          m_nerr = 0;
  int          m_viol = 0;
  logic        cge_prev = 1'b0;
  logic        full_smp = 1'b0;

  always @(posedge CLK) full_smp <= TX_FIFO_FULL;

  always @(negedge CLK) begin
    if (RF_WrEn) m_wr.push_back({RF_Address, RF_WrData});
    if (RF_RdEn) m_rd.push_back(RF_Address);
    if (ALU_EN) begin
      m_alu.push_back(ALU_FUN);
      if (!cge_prev || !CLK_GATE_EN) m_viol <= m_viol + 1;
    end
    if (TX_D_VLD) begin
      m_tx.push_back(TX_P_DATA);
      if (full_smp) m_viol <= m_viol + 1;
    end
    if (FRAME_ERR) m_nerr <= m_nerr + 1;
    cge_prev <= CLK_GATE_EN;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (case %0d): got 0x%0h, expected 0x%0h", nm, cur_id, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] bytes, input int nb, input logic [15:0] resp,
                               input int nwr, input logic [11:0] wr0, input logic [11:0] wr1,
                               input int nrd, input logic [3:0] ra, input int nalu,
                               input logic [3:0] fun, input int ntx, input logic [15:0] txb,
                               input int nerr);
    vec_t v;
    v.bytes = bytes; v.nb = nb; v.resp = resp;
    v.nwr = nwr; v.wr0 = wr0; v.wr1 = wr1; v.nrd = nrd; v.ra = ra;
    v.nalu = nalu; v.fun = fun; v.ntx = ntx; v.txb = txb; v.nerr = nerr;
    return v;
  endfunction

  // Frame-level reference: what a frame starting with bytes[31:24] must do
  function automatic vec_t model(input logic [31:0] bytes, input logic [15:0] resp);
    vec_t v;
    logic [7:0] b1, b2, b3;
    b1 = bytes[23:16]; b2 = bytes[15:8]; b3 = bytes[7:0];
    v = mkv(bytes, 1, resp, 0, 12'h0, 12'h0, 0, 4'h0, 0, 4'h0, 0, 16'h0, 0);
    case (bytes[31:24])
      8'hAA: begin v.nb = 3; v.nwr = 1; v.wr0 = {b1[3:0], b2}; end
      8'hBB: begin v.nb = 2; v.nrd = 1; v.ra = b1[3:0]; v.ntx = 1; v.txb = {8'h00, resp[7:0]}; end
      8'hCC: begin
        v.nb = 4; v.nwr = 2; v.wr0 = {4'h0, b1}; v.wr1 = {4'h1, b2};
        v.nalu = 1; v.fun = b3[3:0]; v.ntx = 2; v.txb = resp;
      end
      8'hDD: begin v.nb = 2; v.nalu = 1; v.fun = b1[3:0]; v.ntx = 2; v.txb = resp; end
      default: v.nerr = 1;
    endcase
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b; RX_D_VLD = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD = 1'b0; RX_P_DATA = 8'($urandom);
  endtask

  // Drive one frame (with optional gaps, noise and backpressure) and check it
  task automatic run_frame(input vec_t v, input bit bp, input bit noise, input int maxgap);
    int bw, br, ba, bt, be, bv, d, k;
    logic [7:0] b0;
    logic [31:0] sh;
    bw = m_wr.size(); br = m_rd.size(); ba = m_alu.size(); bt = m_tx.size();
    be = m_nerr; bv = m_viol;
    b0 = v.bytes[31:24];
    sh = v.bytes;
    for (int i = 0; i < v.nb; i++) begin
      send_byte(sh[31:24]);
      sh = sh << 8;
      if (i < v.nb - 1 && maxgap > 0) idle($urandom_range(maxgap, 0));
    end
    if (b0 == 8'hBB || b0 == 8'hCC || b0 == 8'hDD) begin
      d = $urandom_range(3, 0);
      for (int j = 0; j < d; j++) begin
        if (noise && $urandom_range(1, 0) == 1) send_byte(8'($urandom));
        else idle(1);
      end
      if (b0 == 8'hBB) begin RF_RdData = v.resp[7:0]; RF_RdData_Valid = 1'b1; end
      else begin ALU_OUT = v.resp; ALU_OUT_VLD = 1'b1; end
      @(posedge CLK); #1;
      RF_RdData_Valid = 1'b0; ALU_OUT_VLD = 1'b0;
      RF_RdData = 8'($urandom); ALU_OUT = 16'($urandom);
    end
    k = 0;
    while ((m_tx.size() - bt) < v.ntx && k < 100) begin
      if (bp) TX_FIFO_FULL = ($urandom_range(1, 0) == 1);
      @(posedge CLK); #1;
      k++;
    end
    TX_FIFO_FULL = 1'b0;
    idle(4);
    chk("wr_count", m_wr.size() - bw, v.nwr);
    if (v.nwr > 0 && m_wr.size() > bw)     chk("wr0", m_wr[bw], v.wr0);
    if (v.nwr > 1 && m_wr.size() > bw + 1) chk("wr1", m_wr[bw+1], v.wr1);
    chk("rd_count", m_rd.size() - br, v.nrd);
    if (v.nrd > 0 && m_rd.size() > br)     chk("rd_addr", m_rd[br], v.ra);
    chk("alu_count", m_alu.size() - ba, v.nalu);
    if (v.nalu > 0 && m_alu.size() > ba)   chk("alu_fun", m_alu[ba], v.fun);
    chk("tx_count", m_tx.size() - bt, v.ntx);
    if (v.ntx > 0 && m_tx.size() > bt)     chk("tx0", m_tx[bt], v.txb[7:0]);
    if (v.ntx > 1 && m_tx.size() > bt + 1) chk("tx1", m_tx[bt+1], v.txb[15:8]);
    chk("frame_err", m_nerr - be, v.nerr);
    chk("protocol_viol", m_viol - bv, 0);
    chk("cge_idle", CLK_GATE_EN, 1'b0);
  endtask

  vec_t tbl[10];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int bw, bt, be, bv;
    logic [7:0] b0;
    vec_t v;

    tbl[0] = mkv(32'hAA053C00, 3, 16'h0000, 1, 12'h53C, 12'h000, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 0);
    tbl[1] = mkv(32'hBB050000, 2, 16'h003C, 0, 12'h000, 12'h000, 1, 4'h5, 0, 4'h0, 1, 16'h003C, 0);
    tbl[2] = mkv(32'hCC0A0300, 4, 16'h000D, 2, 12'h00A, 12'h103, 0, 4'h0, 1, 4'h0, 2, 16'h000D, 0);
    tbl[3] = mkv(32'hDDA70000, 2, 16'h1234, 0, 12'h000, 12'h000, 0, 4'h0, 1, 4'h7, 2, 16'h1234, 0);
    tbl[4] = mkv(32'h55000000, 1, 16'h0000, 0, 12'h000, 12'h000, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 1);
    tbl[5] = mkv(32'hAA1F8000, 3, 16'h0000, 1, 12'hF80, 12'h000, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 0);
    tbl[6] = mkv(32'hBBF20000, 2, 16'h00E1, 0, 12'h000, 12'h000, 1, 4'h2, 0, 4'h0, 1, 16'h00E1, 0);
    tbl[7] = mkv(32'hCCFF00F3, 4, 16'hABCD, 2, 12'h0FF, 12'h100, 0, 4'h0, 1, 4'h3, 2, 16'hABCD, 0);
    tbl[8] = mkv(32'h00000000, 1, 16'h0000, 0, 12'h000, 12'h000, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 1);
    tbl[9] = mkv(32'hAB000000, 1, 16'h0000, 0, 12'h000, 12'h000, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 1);

    RST_n = 1'b0; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; RF_RdData = 8'h00;
    RF_RdData_Valid = 1'b0; ALU_OUT = 16'h0000; ALU_OUT_VLD = 1'b0; TX_FIFO_FULL = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    chk("reset_outputs", 32'({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
                              CLK_GATE_EN, TX_P_DATA, TX_D_VLD, FRAME_ERR}), 32'h0);
    @(posedge CLK); #1;
    RST_n = 1'b1;
    idle(2);

    // Directed table: back-to-back bytes, then again with gaps/noise/backpressure
    for (int i = 0; i < 10; i++) begin cur_id = i; run_frame(tbl[i], 1'b0, 1'b0, 0); end
    for (int i = 0; i < 10; i++) begin cur_id = 100 + i; run_frame(tbl[i], 1'b1, 1'b1, 2); end

    // Backpressure: FIFO full for 10 cycles while a result is waiting
    cur_id = 200;
    bt = m_tx.size(); bv = m_viol;
    TX_FIFO_FULL = 1'b1;
    send_byte(8'hDD); send_byte(8'h05);
    ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
    @(posedge CLK); #1;
    ALU_OUT_VLD = 1'b0; ALU_OUT = 16'hFFFF;
    idle(10);
    chk("bp_no_tx_while_full", m_tx.size() - bt, 0);
    chk("bp_byte_held", TX_P_DATA, 8'h34);
    chk("bp_cge_high", CLK_GATE_EN, 1'b1);
    TX_FIFO_FULL = 1'b0;
    idle(6);
    chk("bp_tx_count", m_tx.size() - bt, 2);
    if (m_tx.size() >= bt + 2) begin
      chk("bp_tx_lo", m_tx[bt], 8'h34);
      chk("bp_tx_hi", m_tx[bt+1], 8'h12);
    end
    chk("bp_viol", m_viol - bv, 0);

    // Timeout: AA,05 then silence; error exactly TIMEOUT cycles after 05
    cur_id = 300;
    bw = m_wr.size(); be = m_nerr;
    send_byte(8'hAA); send_byte(8'h05);
    repeat (int'(TO) - 1) @(posedge CLK);
    @(negedge CLK); #1;
    chk("timeout_not_early", m_nerr - be, 0);
    @(posedge CLK); @(negedge CLK); #1;
    chk("timeout_err", m_nerr - be, 1);
    @(posedge CLK); #1;
    chk("timeout_no_write", m_wr.size() - bw, 0);
    idle(2);
    cur_id = 301;
    run_frame(tbl[1], 1'b0, 1'b0, 0);

    // Reset mid-frame discards the partial write
    cur_id = 400;
    bw = m_wr.size();
    send_byte(8'hAA); send_byte(8'h05);
    RST_n = 1'b0;
    @(negedge CLK); #1;
    chk("midreset_cge", CLK_GATE_EN, 1'b0);
    idle(2);
    RST_n = 1'b1;
    idle(1);
    run_frame(tbl[1], 1'b0, 1'b0, 0);
    chk("midreset_no_write", m_wr.size() - bw, 0);

    // Random frames against the protocol model
    for (int i = 0; i < 150; i++) begin
      cur_id = 1000 + i;
      case ($urandom_range(4, 0))
        0: b0 = 8'hAA;
        1: b0 = 8'hBB;
        2: b0 = 8'hCC;
        3: b0 = 8'hDD;
        default: begin
          b0 = 8'($urandom);
          while (b0 == 8'hAA || b0 == 8'hBB || b0 == 8'hCC || b0 == 8'hDD) b0 = 8'($urandom);
        end
      endcase
      v = model({b0, 24'($urandom)}, 16'($urandom));
      run_frame(v, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
